debug_unit: RTL and testbench
=============================

DEBUG_UNIT -- requirements
Module: debug_unit

Interface
REQ-001 Parameter BITS, default 16: instruction/data word width; SHALL equal 16, sent/received as two bytes.
REQ-002 Parameter DTBITS, default 11: program and data memory address width.
REQ-003 Parameter DUMP_WORDS, default 8: number of data-memory words returned after halt, range 1..2^DTBITS.
REQ-004 Port i_clock, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port i_reset, input, 1: reset, asynchronous, active-low.
REQ-006 Port i_rx_data, input, 8: byte from UART receiver.
REQ-007 Port i_rx_done, input, 1: one-cycle pulse, i_rx_data valid.
REQ-008 Port o_tx_data, output, 8: byte to UART transmitter.
REQ-009 Port o_tx_start, output, 1: one-cycle pulse, start transmitting o_tx_data.
REQ-010 Port i_tx_done, input, 1: one-cycle pulse, transmitter finished the current byte.
REQ-011 Port o_prog_we, output, 1: program-memory write strobe.
REQ-012 Port o_prog_addr, output, DTBITS: program-memory write address.
REQ-013 Port o_prog_data, output, BITS: program-memory write data.
REQ-014 Port o_cpu_rst_n, output, 1: processor reset, active-low; low holds the processor in reset.
REQ-015 Port i_halt_flag, input, 1: processor halted.
REQ-016 Port o_ram_addr, output, DTBITS: data-memory debug read address.
REQ-017 Port i_ram_data, input, BITS: data-memory read data, valid one cycle after o_ram_addr changes.
REQ-018 Port o_busy, output, 1: high in every state except IDLE.

Function
REQ-019 States SHALL be IDLE, LD_CNT, LD_HI, LD_LO, LD_WR, RUN, DP_RD, DP_HI, DP_WHI, DP_LO, DP_WLO.
REQ-020 In IDLE, an i_rx_done with byte 0x4C ('L') SHALL go to LD_CNT; 0x52 ('R') to RUN; any other byte SHALL be ignored.
REQ-021 LD_CNT: next received byte SHALL load word counter N and clear the write address to 0; N=0 returns to IDLE with no writes; otherwise go to LD_HI.
REQ-022 LD_HI: next received byte SHALL be stored as data bits [15:8]; go to LD_LO.
REQ-023 LD_LO: next received byte SHALL be stored as bits [7:0]; go to LD_WR.
REQ-024 LD_WR: o_prog_we SHALL be high for exactly one cycle with the current address and assembled word; then address increments, N decrements; N reaching 0 goes to IDLE, else LD_HI.
REQ-025 Every load SHALL start at address 0; N<=255, so the address never wraps.
REQ-026 RUN: o_cpu_rst_n SHALL be high; processor runs until i_halt_flag is sampled high, then go to DP_RD with o_ram_addr=0 and dump counter=DUMP_WORDS.
REQ-027 o_cpu_rst_n SHALL be low in every state except RUN and the DP_* states.
REQ-028 DP_RD: wait one cycle for i_ram_data; go to DP_HI.
REQ-029 DP_HI: o_tx_data=i_ram_data[15:8], o_tx_start pulses one cycle; go to DP_WHI.
REQ-030 DP_WHI: on i_tx_done go to DP_LO.
REQ-031 DP_LO: o_tx_data=i_ram_data[7:0], o_tx_start pulses one cycle; go to DP_WLO.
REQ-032 DP_WLO: on i_tx_done decrement dump counter; if zero go to IDLE, else increment o_ram_addr and go to DP_RD.
REQ-033 o_tx_data SHALL hold its value from the start pulse until the next start pulse.
REQ-034 i_rx_done outside IDLE/LD_* states SHALL be ignored; i_tx_done outside DP_WHI/DP_WLO SHALL be ignored.
REQ-035 i_halt_flag SHALL be ignored outside RUN.
REQ-036 i_rx_done and i_tx_done asserted in the same cycle SHALL each be handled only by the state that consumes it.
REQ-037 o_prog_we, o_tx_start SHALL never be high in the same cycle.

Reset
REQ-038 While i_reset is low: state IDLE, o_cpu_rst_n=0, o_prog_we=0, o_tx_start=0, o_busy=0, o_tx_data=0, o_prog_addr=0, o_prog_data=0, o_ram_addr=0, counters 0.
REQ-039 Reset asserted mid-load or mid-dump SHALL abort immediately; no further write or transmit pulses after release until a new command.

Verification
REQ-040 Send 0x4C,0x02,0x12,0x34,0xAB,0xCD -> o_prog_we pulses twice: addr0=0x1234, addr1=0xABCD; back to IDLE, o_busy=0.
REQ-041 Send 0x4C,0x00 -> no o_prog_we pulse; IDLE.
REQ-042 Send 0x52, raise i_halt_flag after 20 cycles, RAM[0..7]=0x0100+i -> 16 tx bytes 0x01,0x00,0x01,0x01...0x01,0x07, each start only after prior i_tx_done; o_cpu_rst_n low afterwards.
REQ-043 Send 0x55 then 0x4C,0x01,0xFF,0xFF -> 0x55 ignored; single write addr0=0xFFFF.
REQ-044 Assert i_reset after 0x4C,0x03,0x11 -> IDLE, outputs at reset values; subsequent 0x22 byte produces no write.
REQ-045 During dump, pulse i_rx_done with 0x4C -> ignored; dump completes with all 2*DUMP_WORDS bytes.

Source files
------------

// File: rtl/debug_unit.sv
// Debug unit: loads program memory from UART bytes, runs the processor until
// it halts, then streams the first DUMP_WORDS data-memory words back over UART
// as big-endian byte pairs.
module debug_unit #(
  parameter int BITS       = 16,
  parameter int DTBITS     = 11,
  parameter int DUMP_WORDS = 8
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_done,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_start,
  input  logic              i_tx_done,
  output logic              o_prog_we,
  output logic [DTBITS-1:0] o_prog_addr,
  output logic [BITS-1:0]   o_prog_data,
  output logic              o_cpu_rst_n,
  input  logic              i_halt_flag,
  output logic [DTBITS-1:0] o_ram_addr,
  input  logic [BITS-1:0]   i_ram_data,
  output logic              o_busy
);

  typedef enum logic [3:0] {
    IDLE, LD_CNT, LD_HI, LD_LO, LD_WR, RUN,
    DP_RD, DP_HI, DP_WHI, DP_LO, DP_WLO
  } state_t;

  localparam logic [7:0]        CMD_LOAD  = 8'h4C;
  localparam logic [7:0]        CMD_RUN   = 8'h52;
  localparam logic [DTBITS:0]   DUMP_INIT = (DTBITS+1)'(DUMP_WORDS);
  localparam logic [DTBITS:0]   DUMP_ONE  = (DTBITS+1)'(1);
  localparam logic [DTBITS-1:0] ADDR_ONE  = DTBITS'(1);

  state_t            state;
  state_t            state_next;
  logic [7:0]        word_cnt;
  logic [DTBITS:0]   dump_cnt;
  logic [7:0]        tx_hold;

  // State register; reset drops any load or dump in progress straight to IDLE.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic; each state only reacts to the handshake it owns.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (i_rx_done) begin
          if (i_rx_data == CMD_LOAD)     state_next = LD_CNT;
          else if (i_rx_data == CMD_RUN) state_next = RUN;
        end
      end
      LD_CNT: if (i_rx_done) state_next = (i_rx_data == 8'd0) ? IDLE : LD_HI;
      LD_HI:  if (i_rx_done) state_next = LD_LO;
      LD_LO:  if (i_rx_done) state_next = LD_WR;
      LD_WR:  state_next = (word_cnt == 8'd1) ? IDLE : LD_HI;
      RUN:    if (i_halt_flag) state_next = DP_RD;
      DP_RD:  state_next = DP_HI;
      DP_HI:  state_next = DP_WHI;
      DP_WHI: if (i_tx_done) state_next = DP_LO;
      DP_LO:  state_next = DP_WLO;
      DP_WLO: if (i_tx_done) state_next = (dump_cnt == DUMP_ONE) ? IDLE : DP_RD;
      default: state_next = IDLE;
    endcase
  end

  // Transmit byte comes straight from RAM during the start pulse and is held afterwards.
  always_comb begin
    o_tx_data = tx_hold;
    if (state == DP_HI)      o_tx_data = i_ram_data[BITS-1:8];
    else if (state == DP_LO) o_tx_data = i_ram_data[7:0];
  end

  assign o_prog_we   = (state == LD_WR);
  assign o_tx_start  = (state == DP_HI) || (state == DP_LO);
  assign o_busy      = (state != IDLE);
  assign o_cpu_rst_n = (state == RUN)    || (state == DP_RD) || (state == DP_HI) ||
                       (state == DP_WHI) || (state == DP_LO) || (state == DP_WLO);

  // Datapath: word assembly, load/dump addresses and counters, held tx byte.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      word_cnt    <= '0;
      dump_cnt    <= '0;
      o_prog_addr <= '0;
      o_prog_data <= '0;
      o_ram_addr  <= '0;
      tx_hold     <= '0;
    end else begin
      case (state)
        LD_CNT: begin
          if (i_rx_done) begin
            word_cnt    <= i_rx_data;
            o_prog_addr <= '0;
          end
        end
        LD_HI: if (i_rx_done) o_prog_data[BITS-1:8] <= i_rx_data;
        LD_LO: if (i_rx_done) o_prog_data[7:0] <= i_rx_data;
        LD_WR: begin
          o_prog_addr <= o_prog_addr + ADDR_ONE;
          word_cnt    <= word_cnt - 8'd1;
        end
        RUN: begin
          if (i_halt_flag) begin
            o_ram_addr <= '0;
            dump_cnt   <= DUMP_INIT;
          end
        end
        DP_HI, DP_LO: tx_hold <= o_tx_data;
        DP_WLO: begin
          if (i_tx_done) begin
            dump_cnt <= dump_cnt - DUMP_ONE;
            if (dump_cnt != DUMP_ONE) o_ram_addr <= o_ram_addr + ADDR_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_unit.sv
// Directed bench for debug_unit: drives UART bytes, models a synchronous data
// RAM and a UART transmitter, and checks writes and dumped bytes.
module tb_debug_unit;

  localparam int DTBITS = 11;

  logic              i_clock;
  logic              i_reset;
  logic [7:0]        i_rx_data;
  logic              i_rx_done;
  logic [7:0]        o_tx_data;
  logic              o_tx_start;
  logic              i_tx_done;
  logic              o_prog_we;
  logic [DTBITS-1:0] o_prog_addr;
  logic [15:0]       o_prog_data;
  logic              o_cpu_rst_n;
  logic              i_halt_flag;
  logic [DTBITS-1:0] o_ram_addr;
  logic [15:0]       i_ram_data;
  logic              o_busy;

  int errors = 0;
  int checks = 0;

  logic [DTBITS-1:0] wr_addr_q[$];
  logic [15:0]       wr_data_q[$];
  logic [7:0]        tx_q[$];
  int                tx_cnt = 0;
  int                early_start = 0;
  int                both_high = 0;
  logic [15:0]       mem [0:2047];

  debug_unit #(.BITS(16), .DTBITS(DTBITS), .DUMP_WORDS(8)) dut (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_rx_data   (i_rx_data),
    .i_rx_done   (i_rx_done),
    .o_tx_data   (o_tx_data),
    .o_tx_start  (o_tx_start),
    .i_tx_done   (i_tx_done),
    .o_prog_we   (o_prog_we),
    .o_prog_addr (o_prog_addr),
    .o_prog_data (o_prog_data),
    .o_cpu_rst_n (o_cpu_rst_n),
    .i_halt_flag (i_halt_flag),
    .o_ram_addr  (o_ram_addr),
    .i_ram_data  (i_ram_data),
    .o_busy      (o_busy)
  );

  // Free-running clock.
  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  // Synchronous-read data memory: data valid one cycle after the address.
  always @(posedge i_clock) i_ram_data <= mem[o_ram_addr];

  // Monitor and UART transmitter model, sampled mid-cycle.
  always @(negedge i_clock) begin
    if (o_prog_we) begin
      wr_addr_q.push_back(o_prog_addr);
      wr_data_q.push_back(o_prog_data);
    end
    if (o_prog_we && o_tx_start) both_high++;
    i_tx_done = 1'b0;
    if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) i_tx_done = 1'b1;
    end
    if (o_tx_start) begin
      if (tx_cnt != 0) early_start++;
      tx_q.push_back(o_tx_data);
      tx_cnt = 3;
    end
  end

  // Hard stop in case a sequence wedges.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    @(negedge i_clock);
    i_rx_data = b;
    i_rx_done = 1'b1;
    @(negedge i_clock);
    i_rx_done = 1'b0;
    @(negedge i_clock);
  endtask

  task automatic waitIdle(input string tag, input int budget);
    int n = 0;
    while (o_busy && n < budget) begin
      @(negedge i_clock);
      n++;
    end
    checkOutput(tag, 32'(o_busy), 32'd0);
  endtask

  task automatic clearLogs();
    wr_addr_q.delete();
    wr_data_q.delete();
    tx_q.delete();
  endtask

  // Directed sequence.
  initial begin
    int n;
    logic [7:0] exp_b;
    for (int i = 0; i < 2048; i++) mem[i] = 16'hDEAD;
    for (int i = 0; i < 8; i++) mem[i] = 16'h0100 + 16'(i);
    i_reset = 1'b0;
    i_rx_data = 8'h00;
    i_rx_done = 1'b0;
    i_halt_flag = 1'b0;
    i_tx_done = 1'b0;
    repeat (3) @(negedge i_clock);

    checkOutput("rst_busy",    32'(o_busy),      32'd0);
    checkOutput("rst_cpu_rst", 32'(o_cpu_rst_n), 32'd0);
    checkOutput("rst_prog_we", 32'(o_prog_we),   32'd0);
    checkOutput("rst_tx_start",32'(o_tx_start),  32'd0);
    checkOutput("rst_tx_data", 32'(o_tx_data),   32'd0);
    checkOutput("rst_addr",    32'(o_prog_addr), 32'd0);
    checkOutput("rst_data",    32'(o_prog_data), 32'd0);
    checkOutput("rst_ram_addr",32'(o_ram_addr),  32'd0);
    i_reset = 1'b1;
    @(negedge i_clock);

    // Two-word load.
    clearLogs();
    applyStimulus(8'h4C);
    checkOutput("ld_busy", 32'(o_busy), 32'd1);
    applyStimulus(8'h02);
    applyStimulus(8'h12);
    applyStimulus(8'h34);
    applyStimulus(8'hAB);
    applyStimulus(8'hCD);
    repeat (3) @(negedge i_clock);
    checkOutput("ld2_count", 32'(wr_addr_q.size()), 32'd2);
    if (wr_addr_q.size() == 2) begin
      checkOutput("ld2_addr0", 32'(wr_addr_q[0]), 32'd0);
      checkOutput("ld2_data0", 32'(wr_data_q[0]), 32'h1234);
      checkOutput("ld2_addr1", 32'(wr_addr_q[1]), 32'd1);
      checkOutput("ld2_data1", 32'(wr_data_q[1]), 32'hABCD);
    end
    checkOutput("ld2_busy",    32'(o_busy),      32'd0);
    checkOutput("ld2_cpu_rst", 32'(o_cpu_rst_n), 32'd0);

    // Zero-length load.
    clearLogs();
    applyStimulus(8'h4C);
    applyStimulus(8'h00);
    repeat (3) @(negedge i_clock);
    checkOutput("ld0_count", 32'(wr_addr_q.size()), 32'd0);
    checkOutput("ld0_busy",  32'(o_busy), 32'd0);

    // Unknown command ignored, then single-word load.
    clearLogs();
    applyStimulus(8'h55);
    checkOutput("unk_busy", 32'(o_busy), 32'd0);
    applyStimulus(8'h4C);
    applyStimulus(8'h01);
    applyStimulus(8'hFF);
    applyStimulus(8'hFF);
    repeat (3) @(negedge i_clock);
    checkOutput("ld1_count", 32'(wr_addr_q.size()), 32'd1);
    if (wr_addr_q.size() == 1) begin
      checkOutput("ld1_addr0", 32'(wr_addr_q[0]), 32'd0);
      checkOutput("ld1_data0", 32'(wr_data_q[0]), 32'hFFFF);
    end

    // Run, halt, full dump.
    clearLogs();
    applyStimulus(8'h52);
    checkOutput("run_cpu_rst", 32'(o_cpu_rst_n), 32'd1);
    checkOutput("run_busy",    32'(o_busy),      32'd1);
    repeat (20) @(negedge i_clock);
    i_halt_flag = 1'b1;
    waitIdle("dump_idle", 1000);
    i_halt_flag = 1'b0;
    checkOutput("dump_count", 32'(tx_q.size()), 32'd16);
    if (tx_q.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        exp_b = (i % 2 == 0) ? 8'h01 : 8'(i / 2);
        checkOutput($sformatf("dump_byte%0d", i), 32'(tx_q[i]), 32'(exp_b));
      end
    end
    checkOutput("dump_early",   32'(early_start), 32'd0);
    checkOutput("dump_cpu_rst", 32'(o_cpu_rst_n), 32'd0);
    checkOutput("dump_hold",    32'(o_tx_data),   32'h07);

    // Received 'L' during dump is ignored.
    clearLogs();
    applyStimulus(8'h52);
    repeat (5) @(negedge i_clock);
    i_halt_flag = 1'b1;
    n = 0;
    while (tx_q.size() < 2 && n < 200) begin
      @(negedge i_clock);
      n++;
    end
    applyStimulus(8'h4C);
    waitIdle("dumprx_idle", 1000);
    i_halt_flag = 1'b0;
    checkOutput("dumprx_count",  32'(tx_q.size()),      32'd16);
    checkOutput("dumprx_writes", 32'(wr_addr_q.size()), 32'd0);
    repeat (3) @(negedge i_clock);
    checkOutput("dumprx_busy",   32'(o_busy),           32'd0);

    // Reset mid-load aborts it.
    clearLogs();
    applyStimulus(8'h4C);
    applyStimulus(8'h03);
    applyStimulus(8'h11);
    i_reset = 1'b0;
    @(negedge i_clock);
    checkOutput("ldrst_busy",    32'(o_busy),      32'd0);
    checkOutput("ldrst_data",    32'(o_prog_data), 32'd0);
    checkOutput("ldrst_addr",    32'(o_prog_addr), 32'd0);
    checkOutput("ldrst_cpu_rst", 32'(o_cpu_rst_n), 32'd0);
    i_reset = 1'b1;
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    applyStimulus(8'h44);
    repeat (3) @(negedge i_clock);
    checkOutput("ldrst_writes", 32'(wr_addr_q.size()), 32'd0);
    checkOutput("ldrst_busy2",  32'(o_busy),           32'd0);

    // Reset mid-dump aborts it.
    clearLogs();
    applyStimulus(8'h52);
    repeat (3) @(negedge i_clock);
    i_halt_flag = 1'b1;
    n = 0;
    while (tx_q.size() < 3 && n < 200) begin
      @(negedge i_clock);
      n++;
    end
    i_reset = 1'b0;
    i_halt_flag = 1'b0;
    @(negedge i_clock);
    n = tx_q.size();
    checkOutput("dprst_tx_data", 32'(o_tx_data),   32'd0);
    checkOutput("dprst_cpu_rst", 32'(o_cpu_rst_n), 32'd0);
    i_reset = 1'b1;
    repeat (40) @(negedge i_clock);
    checkOutput("dprst_no_tx", 32'(tx_q.size()), 32'(n));
    checkOutput("dprst_busy",  32'(o_busy),      32'd0);

    checkOutput("we_tx_overlap", 32'(both_high), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
